// File: rtl/maze_pkg.sv
// maze_pkg: shared constants for the maze store.
//   Cell codes (CELL_FREE / CELL_WALL / CELL_VISITED), FSM state encodings,
//   MAZE_CELLS for the default 64x64 maze, and the raw-to-code decode helper.
package maze_pkg;

  localparam logic [1:0] CELL_FREE    = 2'd0;
  localparam logic [1:0] CELL_WALL    = 2'd1;
  localparam logic [1:0] CELL_VISITED = 2'd2;

  localparam int MAZE_CELLS = 4096;

  localparam logic [2:0] ST_LOAD     = 3'd0;
  localparam logic [2:0] ST_SERVE    = 3'd1;
  localparam logic [2:0] ST_DUMP_RD  = 3'd2;
  localparam logic [2:0] ST_DUMP_OUT = 3'd3;
  localparam logic [2:0] ST_FINISH   = 3'd4;

  // Storage keeps {visited, wall} bits. A wall that was later marked visited
  // is stored as 2'b11 and must still report as WALL.
  function automatic logic [1:0] cell_code(input logic [1:0] raw);
    if (raw[0])      return CELL_WALL;
    else if (raw[1]) return CELL_VISITED;
    else             return CELL_FREE;
  endfunction

endpackage

// File: rtl/maze_cell_ram.sv
// maze_cell_ram: maze_size^2 x 2-bit simple dual-port synchronous RAM.
//   clk            : clock
//   we/wmask/waddr/wdata : write port, per-bit write mask
//   re/raddr/rdata : registered read port, rdata holds while re = 0
// Read-before-write on an address collision (rdata gets the old value).
module maze_cell_ram #(
  parameter int maze_width = 6,
  parameter int maze_size  = 1 << maze_width
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [1:0]                wmask,
  input  logic [2*maze_width-1:0]   waddr,
  input  logic [1:0]                wdata,
  input  logic                      re,
  input  logic [2*maze_width-1:0]   raddr,
  output logic [1:0]                rdata
);

  logic [1:0] mem [0:maze_size*maze_size-1];

  // Per-bit mask lets a visited mark set only bit 1, so the wall bit of the
  // target cell is never touched and a WALL stays a WALL.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++)
      if (we && wmask[b]) mem[waddr][b] <= wdata[b];
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/maze_store.sv
// maze_store: 64x64 maze storage for the maze solver.
//   clk, rst                     : clock, synchronous active-high reset
//   load_valid/load_data/load_ready : row-major maze load stream (1 = wall)
//   maze_ready                   : maze loaded, solver port live
//   row/col/maze_oe/maze_we/maze_in : solver cell port, 1-cycle read latency
//   done                         : solver finished
//   dump_valid/dump_data/dump_last/dump_ready : cell-code dump stream
// Build option: define MAZE_DUMP_EN to build the dump path; otherwise done
// goes straight to FINISH and the dump outputs are tied to 0.
import maze_pkg::*;

module maze_store #(
  parameter int maze_width = 6,
  parameter int maze_size  = 1 << maze_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic                  load_data,
  output logic                  load_ready,
  output logic                  maze_ready,
  input  logic [maze_width-1:0] row,
  input  logic [maze_width-1:0] col,
  input  logic                  maze_oe,
  input  logic                  maze_we,
  output logic                  maze_in,
  input  logic                  done,
  output logic                  dump_valid,
  output logic [1:0]            dump_data,
  output logic                  dump_last,
  input  logic                  dump_ready
);

  localparam int PTR_W = 2 * maze_width;

  logic [2:0]       state;
  logic [PTR_W-1:0] ptr;
  logic             rd_pend;    // rdata holds a solver read result this cycle
  logic             maze_in_q;  // last value shown on maze_in

  logic             serve, load_hs, ptr_last;
  logic [PTR_W-1:0] cell_addr;

  logic             ram_we, ram_re;
  logic [1:0]       ram_wmask, ram_wdata, rdata;
  logic [PTR_W-1:0] ram_waddr, ram_raddr;

  assign serve      = (state == ST_SERVE);
  assign load_ready = (state == ST_LOAD);
  assign maze_ready = serve;
  assign load_hs    = load_ready && load_valid;
  assign ptr_last   = &ptr;
  assign cell_addr  = {row, col};

  // rdata is the registered RAM output, so the solver result is valid the
  // cycle after maze_oe; otherwise maze_in replays its previous value.
  assign maze_in = rd_pend ? rdata[0] : maze_in_q;

  always_comb begin
    ram_we    = 1'b0;
    ram_wmask = 2'b00;
    ram_waddr = cell_addr;
    ram_wdata = CELL_VISITED;
    ram_re    = 1'b0;
    ram_raddr = cell_addr;
    if (load_hs) begin
      // A load rewrites both bits, clearing any stale visited mark.
      ram_we    = 1'b1;
      ram_wmask = 2'b11;
      ram_waddr = ptr;
      ram_wdata = {1'b0, load_data};
    end else if (serve && maze_we) begin
      ram_we    = 1'b1;
      ram_wmask = 2'b10;
    end
    if (serve && maze_oe) ram_re = 1'b1;
`ifdef MAZE_DUMP_EN
    if (state == ST_DUMP_RD) begin
      ram_re    = 1'b1;
      ram_raddr = ptr;
    end
`endif
  end

  maze_cell_ram #(.maze_width(maze_width), .maze_size(maze_size)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .wmask (ram_wmask),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      ptr       <= '0;
      rd_pend   <= 1'b0;
      maze_in_q <= 1'b1;
    end else begin
      rd_pend   <= serve && maze_oe;
      maze_in_q <= maze_in;
      case (state)
        ST_LOAD: if (load_valid) begin
          if (ptr_last) begin
            ptr   <= '0;
            state <= ST_SERVE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        ST_SERVE: if (done) begin
          ptr <= '0;
`ifdef MAZE_DUMP_EN
          state <= ST_DUMP_RD;
`else
          state <= ST_FINISH;
`endif
        end
`ifdef MAZE_DUMP_EN
        ST_DUMP_RD: state <= ST_DUMP_OUT;
        ST_DUMP_OUT: if (dump_ready) begin
          if (ptr_last) begin
            state <= ST_FINISH;
          end else begin
            ptr   <= ptr + 1'b1;
            state <= ST_DUMP_RD;
          end
        end
`endif
        default: ;  // FINISH: parked until reset
      endcase
    end
  end

`ifdef MAZE_DUMP_EN
  // rdata and ptr are frozen while in DUMP_OUT, so the presented cell stays
  // stable across any amount of backpressure.
  assign dump_valid = (state == ST_DUMP_OUT);
  assign dump_data  = dump_valid ? cell_code(rdata) : CELL_FREE;
  assign dump_last  = dump_valid && ptr_last;
`else
  logic dump_unused;
  assign dump_unused = dump_ready ^ rdata[1];
  assign dump_valid  = 1'b0;
  assign dump_data   = 2'b00;
  assign dump_last   = 1'b0;
`endif

endmodule

// File: doc/maze_store.md
# maze_store

- Owns the 64x64 maze storage for the maze solver.
- Accepts the maze from the upstream loader as a row-major bit stream over a valid/ready handshake.
- Serves the solver's synchronous read/write cell port (`row`, `col`, `maze_oe`, `maze_we` → `maze_in`).
- After the solver raises `done`, streams every cell back out with visited marks so the found path can be displayed or checked.

## Interface

Parameters:

- `maze_width`, default 6: row/column index width.
- `maze_size` = 1 << `maze_width`: cells per side. Total cells = `maze_size`².

Ports:

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `load_valid` in 1: loader presents a cell.
- `load_data` in 1: 1 = wall, 0 = free.
- `load_ready` out 1: store accepts a cell.
- `maze_ready` out 1: full maze loaded; the solver port is live.
- `row`, `col` in `maze_width`: cell address from the solver.
- `maze_oe` in 1: read strobe.
- `maze_we` in 1: write strobe; marks the addressed cell visited.
- `maze_in` out 1: read result, 1 = wall. Named as at the solver so the two connect directly.
- `done` in 1: solver has found the exit.
- `dump_valid` out 1: dump cell presented.
- `dump_data` out 2: cell code.
- `dump_last` out 1: final cell (row 63, col 63).
- `dump_ready` in 1: consumer accepts the dump cell.

## Operation

Cell codes: FREE = 0, WALL = 1, VISITED = 2.

State machine: LOAD → SERVE → DUMP_RD ⇄ DUMP_OUT → FINISH.

- **Reset:**
  - Enters LOAD with `ptr` = 0. `ptr` is a 2·`maze_width`-bit linear index.
  - Cell contents are not cleared.
  - Reset takes effect from any state, including mid-load and mid-dump. The partial load or dump is abandoned, and the next load restarts at cell 0.
- **LOAD:**
  - `load_ready` = 1.
  - Each cycle with `load_valid` & `load_ready`: cell[`ptr`] ← {0, `load_data`}, then `ptr`++.
  - Index = row·`maze_size` + col.
  - The handshake at `ptr` = 4095 moves to SERVE and clears `ptr`.
  - Solver strobes in LOAD are ignored. `maze_in` is held at 1, so an early solver sees walls and makes no progress.
- **SERVE:**
  - `maze_ready` = 1, `load_ready` = 0.
  - `maze_oe` = 1: `maze_in` ← (cell[row,col] == WALL), registered at the same edge.
  - `maze_we` = 1: cell[row,col] ← VISITED. A write never changes a WALL cell.
  - Both strobes to the same cell in one cycle: the read returns the pre-write value.
  - `maze_in` holds its last value when `maze_oe` = 0.
  - `done` sampled 1 → DUMP_RD with `ptr` = 0.
  - `done` has priority over strobes in the same cycle: the strobe is still performed.
- **DUMP_RD:** issues a read of cell[`ptr`] and moves to DUMP_OUT.
- **DUMP_OUT:**
  - `dump_valid` = 1, `dump_data` = the cell code, `dump_last` = (`ptr` == 4095).
  - `dump_data` and `dump_last` are held stable until `dump_ready`.
  - On handshake: if last, go to FINISH; otherwise `ptr`++ and return to DUMP_RD.
- **FINISH:**
  - All strobes are ignored and `dump_valid` = 0.
  - The block stays in FINISH until `rst`.

## Timing

- Reset values:
  - `load_ready` = 1 (decoded from LOAD).
  - `maze_ready` = 0.
  - `maze_in` = 1.
  - `dump_valid` = 0, `dump_data` = 0, `dump_last` = 0.
- Load throughput: 1 cell/cycle. A full load takes 4096 handshakes.
- `maze_ready` rises one cycle after the last load handshake.
- Read latency: 1 cycle. `maze_in` is valid in the cycle after `maze_oe`, which matches the solver's move-then-check two-state loop.
- Write takes effect at the edge where `maze_we` is sampled. A read in the following cycle sees VISITED.
- Dump throughput: 1 cell per 2 cycles at best.
- `dump_valid` first rises 2 cycles after `done` is sampled.
- Backpressure: any number of `dump_ready` = 0 cycles stalls the dump without loss or duplication.

## Configuration

- `MAZE_DUMP_EN` defined: DUMP_RD and DUMP_OUT exist, and the dump port operates as above.
- `MAZE_DUMP_EN` undefined:
  - `done` moves SERVE directly to FINISH.
  - `dump_valid`, `dump_data` and `dump_last` are tied to 0.
  - `dump_ready` is unused.
  - No dump counter logic is built.

## Structure

- Package `maze_pkg` holds:
  - the cell codes `CELL_FREE`, `CELL_WALL`, `CELL_VISITED`;
  - the state encodings;
  - the constant `MAZE_CELLS` = 4096.
- Sub-module `maze_cell_ram`: a `maze_size`² × 2-bit simple dual-port synchronous RAM.
  - One write port: load or visited-mark.
  - One registered read port: solver read or dump read.
  - Read-before-write on an address collision.
- `maze_store` contains the FSM, `ptr`, the port multiplexing and the output registers.

## Test plan

- **Reset then load:** stream 4096 cells with walls on all borders except (0,5), with `load_valid` toggling every other cycle.
  - `load_ready` stays 1 throughout.
  - `maze_ready` rises exactly one cycle after the 4096th handshake.
- **Solver port:** `maze_oe` at (1,1) = free, then (0,0) = wall. `maze_in` is 0, then 1, each one cycle later.
  - Then `maze_we` + `maze_oe` at (1,1) in the same cycle: `maze_in` is 0 (old value).
  - A later read of (1,1) gives `maze_in` = 0, and its dump code is 2.
- **Write to wall:** `maze_we` at (0,0). The dump later shows code 1 at index 0.
- **Dump with backpressure:** `done` pulse, with `dump_ready` low for 5 cycles on cell 10.
  - `dump_data` is held stable for the stall.
  - Exactly 4096 transfers occur, with `dump_last` only on index 4095.
  - The block then sits in FINISH with `dump_valid` = 0.
- **Reset mid-load at cell 2000:** `maze_ready` stays 0. A fresh full load then succeeds from cell 0.
- **Build without `MAZE_DUMP_EN`:** `done` gives `dump_valid` = 0 forever, and solver strobes after `done` are ignored.
